// File: rtl/issue_scheduler.sv
// Single-entry issue buffer between fetch and decode with a per-register countdown scoreboard.
// Optional hazard statistics counters are enabled with `define HAZARD_STATS_EN.
module issue_scheduler #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ENC_W    = 2,
    parameter int unsigned WB_LAT   = 5,
    parameter int unsigned CNT_W    = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    input  logic [7:0]          in_instr,
    output logic                in_ready,
    input  logic                flush,
    output logic                issue_valid,
    output logic [7:0]          issue_instr,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy,
    output logic [15:0]         stall_cycles,
    output logic [15:0]         issued_count
);

    typedef enum logic {S_EMPTY, S_HELD} state_t;

    state_t           state_q, state_d;
    logic [7:0]       hold_instr_q, hold_instr_d;
    logic             issue_valid_q, issue_valid_d;
    logic [7:0]       issue_instr_q, issue_instr_d;
    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    logic             hold_valid;
    logic [2:0]       hold_op;
    logic [ENC_W-1:0] rs_a, rs_b;
    logic             use_a, use_b, regwrite;
    logic             hazard;
    logic             accept, issue;

    // Decode of the held instruction; INC reads only rd/rs1.
    always_comb begin
        hold_valid = (state_q == S_HELD);
        hold_op    = hold_instr_q[6:4];
        rs_a       = hold_instr_q[3:2];
        rs_b       = hold_instr_q[1:0];
        regwrite   = (hold_op != 3'b000);
        use_a      = regwrite;
        use_b      = regwrite && (hold_op != 3'b011);
        hazard     = hold_valid && ((use_a && (cnt_q[rs_a] != '0)) ||
                                    (use_b && (cnt_q[rs_b] != '0)));
        in_ready   = !hold_valid || !hazard;
        stall      = hold_valid && hazard;
        accept     = in_valid && in_ready && !flush;
        issue      = hold_valid && !hazard && !flush;
    end

    // Hold-register FSM and issue output; flush wins over accept and issue.
    always_comb begin
        state_d       = state_q;
        hold_instr_d  = hold_instr_q;
        issue_valid_d = 1'b0;
        issue_instr_d = 8'h00;
        if (flush) begin
            state_d      = S_EMPTY;
            hold_instr_d = 8'h00;
        end else begin
            if (issue) begin
                issue_valid_d = 1'b1;
                issue_instr_d = hold_instr_q;
                state_d       = S_EMPTY;
            end
            if (accept) begin
                state_d      = S_HELD;
                hold_instr_d = in_instr;
            end
        end
    end

    // Scoreboard: a new writer restarts its register's count, others drain to zero.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            busy[i]  = (cnt_q[i] != '0);
            if (issue && regwrite && (rs_a == ENC_W'(i))) begin
                cnt_d[i] = CNT_W'(WB_LAT - 1);
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_EMPTY;
            hold_instr_q  <= 8'h00;
            issue_valid_q <= 1'b0;
            issue_instr_q <= 8'h00;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            hold_instr_q  <= hold_instr_d;
            issue_valid_q <= issue_valid_d;
            issue_instr_q <= issue_instr_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_instr = issue_instr_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] issued_count_q, issued_count_d;

    // Stall count saturates; issue count wraps.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        issued_count_d = issued_count_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
        if (issue) issued_count_d = issued_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles_q <= 16'h0000;
            issued_count_q <= 16'h0000;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            issued_count_q <= issued_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign issued_count = issued_count_q;
`else
    assign stall_cycles = 16'h0000;
    assign issued_count = 16'h0000;
`endif

endmodule
